// File: rtl/fifomult_param.sv
// ============================================================================
// Module   : fifomult_param
// Purpose  : Serial-operand (A then B) multiplier with parity checking, a
//            two-stage product pipeline and a valid/ready output FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifomult_param #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              data_in,
    input  logic                           data_in_parity,
    input  logic                           data_in_valid,
    output logic                           busy_out,
    output logic [2*DATA_W-1:0]            data_out,
    output logic                           data_out_parity,
    output logic                           data_out_valid,
    input  logic                           data_out_ready,
    output logic                           data_in_parity_error,
    output logic [$clog2(OUT_DEPTH+1)-1:0] result_count
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int PTR_W  = $clog2(OUT_DEPTH);
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(OUT_DEPTH);

    typedef enum logic [0:0] {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_err_a;
    logic                r_err_b;
    logic                r_issue_v;
    logic [PROD_W-1:0]   r_s1_prod;
    logic                r_s1_err;
    logic                r_s1_v;
    logic [PROD_W-1:0]   r_mem_data [OUT_DEPTH];
    logic                r_mem_par  [OUT_DEPTH];
    logic                r_mem_err  [OUT_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_busy;

    logic                w_accept;
    logic                w_in_err;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_inflight;
    logic [CNT_W:0]      w_occupancy;
    logic [PROD_W-1:0]   w_a_ext;
    logic [PROD_W-1:0]   w_b_ext;
    logic [PROD_W-1:0]   w_prod;

    assign w_accept = data_in_valid & ~r_busy;
    assign w_in_err = data_in_parity ^ (^data_in);

    // Extending both operands to the full product width makes the truncated
    // product exact for either signedness.
    generate
        if (SIGNED) begin : g_signed
            assign w_a_ext = {{DATA_W{r_a[DATA_W-1]}}, r_a};
            assign w_b_ext = {{DATA_W{r_b[DATA_W-1]}}, r_b};
        end else begin : g_unsigned
            assign w_a_ext = {{DATA_W{1'b0}}, r_a};
            assign w_b_ext = {{DATA_W{1'b0}}, r_b};
        end
    endgenerate

    assign w_prod = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WAIT_A;
            r_a       <= '0;
            r_b       <= '0;
            r_err_a   <= 1'b0;
            r_err_b   <= 1'b0;
            r_issue_v <= 1'b0;
        end else begin
            r_issue_v <= 1'b0;
            if (w_accept) begin
                if (r_state == WAIT_A) begin
                    r_a     <= data_in;
                    r_err_a <= w_in_err;
                    r_state <= WAIT_B;
                end else begin
                    r_b       <= data_in;
                    r_err_b   <= w_in_err;
                    r_issue_v <= 1'b1;
                    r_state   <= WAIT_A;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_err  <= 1'b0;
            r_s1_prod <= '0;
        end else begin
            r_s1_v <= r_issue_v;
            if (r_issue_v) begin
                r_s1_err  <= r_err_a | r_err_b;
                r_s1_prod <= (r_err_a | r_err_b) ? '0 : w_prod;
            end
        end
    end

    assign w_push = r_s1_v;
    assign w_pop  = data_out_valid & data_out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_s1_prod;
            r_mem_par[r_wr_ptr]  <= ^r_s1_prod;
            r_mem_err[r_wr_ptr]  <= r_s1_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Everything accepted but not yet popped, including a half-collected pair;
    // the one-cycle lag of the registered flag is safe because only an A
    // acceptance grows this sum and it must be followed by a neutral B.
    assign w_inflight  = {1'b0, r_issue_v} + {1'b0, r_s1_v} + {1'b0, (r_state == WAIT_B)};
    assign w_occupancy = {1'b0, r_count} + (CNT_W + 1)'(w_inflight);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_occupancy >= C_DEPTH);
        end
    end

    assign busy_out             = r_busy;
    assign result_count         = r_count;
    assign data_out_valid       = (r_count != '0);
    assign data_out             = data_out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign data_out_parity      = data_out_valid ? r_mem_par[r_rd_ptr]  : 1'b0;
    assign data_in_parity_error = data_out_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fifomult_param.sv
// ============================================================================
// Module   : tb_fifomult_param
// Purpose  : Self-checking bench for fifomult_param (signed and unsigned
//            instances driven in lockstep against a transaction-level model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifomult_param;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        data_in_parity;
    logic        data_in_valid;
    logic        data_out_ready;

    logic        busy_s, dpar_s, dval_s, derr_s;
    logic [31:0] dout_s;
    logic [2:0]  cnt_s;
    logic        busy_u, dpar_u, dval_u, derr_u;
    logic [31:0] dout_u;
    logic [2:0]  cnt_u;

    int errors = 0;
    int checks = 0;

    fifomult_param #(.DATA_W(16), .OUT_DEPTH(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_parity(data_in_parity),
        .data_in_valid(data_in_valid), .busy_out(busy_s), .data_out(dout_s),
        .data_out_parity(dpar_s), .data_out_valid(dval_s), .data_out_ready(data_out_ready),
        .data_in_parity_error(derr_s), .result_count(cnt_s)
    );

    fifomult_param #(.DATA_W(16), .OUT_DEPTH(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_parity(data_in_parity),
        .data_in_valid(data_in_valid), .busy_out(busy_u), .data_out(dout_u),
        .data_out_parity(dpar_u), .data_out_valid(dval_u), .data_out_ready(data_out_ready),
        .data_in_parity_error(derr_u), .result_count(cnt_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each completed pair is one transaction stamped with the edge
    // at which its B was accepted; it becomes visible two edges later.
    typedef struct {
        int unsigned edge_n;
        logic [15:0] a;
        logic [15:0] b;
        logic        err;
    } ent_t;

    ent_t        q[$];
    logic        m_half = 1'b0;
    logic [15:0] m_a = '0;
    logic        m_err_a = 1'b0;
    logic        m_busy = 1'b0;
    int unsigned edge_cnt = 0;

    function automatic logic [31:0] prod_s(input logic [15:0] a, input logic [15:0] b);
        longint x;
        x = longint'($signed(a)) * longint'($signed(b));
        return x[31:0];
    endfunction

    function automatic logic [31:0] prod_u(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          vis = 0;
        logic [31:0] es = '0;
        logic [31:0] eu = '0;
        logic        ee = 1'b0;
        foreach (q[i]) if (q[i].edge_n + 2 <= edge_cnt) vis++;
        if (vis > 0) begin
            ee = q[0].err;
            if (!ee) begin
                es = prod_s(q[0].a, q[0].b);
                eu = prod_u(q[0].a, q[0].b);
            end
        end
        chk("s_valid", 64'(dval_s), 64'(vis > 0));
        chk("s_count", 64'(cnt_s),  64'(vis));
        chk("s_busy",  64'(busy_s), 64'(m_busy));
        chk("s_data",  64'(dout_s), 64'(es));
        chk("s_par",   64'(dpar_s), 64'(^es));
        chk("s_err",   64'(derr_s), 64'(ee));
        chk("u_valid", 64'(dval_u), 64'(vis > 0));
        chk("u_count", 64'(cnt_u),  64'(vis));
        chk("u_busy",  64'(busy_u), 64'(m_busy));
        chk("u_data",  64'(dout_u), 64'(eu));
        chk("u_par",   64'(dpar_u), 64'(^eu));
        chk("u_err",   64'(derr_u), 64'(ee));
    endtask

    task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                       input logic bad, input logic rdy);
        int   occ;
        logic acc;
        logic pop;
        logic e;
        rst            = r;
        data_in_valid  = v;
        data_in        = d;
        data_in_parity = (^d) ^ bad;
        data_out_ready = rdy;
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            q.delete();
            m_half = 1'b0;
            m_busy = 1'b0;
        end else begin
            occ    = q.size() + (m_half ? 1 : 0);
            acc    = v && !m_busy;
            pop    = rdy && (q.size() > 0) && (edge_cnt >= q[0].edge_n + 3);
            m_busy = (occ >= 4);
            if (pop) void'(q.pop_front());
            if (acc) begin
                e = bad;
                if (!m_half) begin
                    m_a = d; m_err_a = e; m_half = 1'b1;
                end else begin
                    q.push_back('{edge_cnt, m_a, d, m_err_a | e});
                    m_half = 1'b0;
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, rdy);
    endtask

    // Sends A then B, waits two edges so the product sits at the FIFO head.
    task automatic pair_to_head(input logic [15:0] a, input logic [15:0] b,
                                input logic bad_a, input logic rdy);
        cyc(1'b0, 1'b1, a, bad_a, rdy);
        cyc(1'b0, 1'b1, b, 1'b0, rdy);
        idle(2, rdy);
    endtask

    function automatic logic [15:0] corner();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; data_in = '0; data_in_parity = 1'b0;
        data_in_valid = 1'b0; data_out_ready = 1'b0;

        // 1: reset, then reset again mid-pair; no stale A survives
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        idle(1, 1'b1);
        cyc(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        idle(2, 1'b1);
        pair_to_head(16'h0003, 16'h0005, 1'b0, 1'b1);
        chk("stale_a_prod", 64'(dout_s), 64'h0000_000F);

        // 2/3: signed and unsigned corner products
        idle(2, 1'b1);
        pair_to_head(16'h7FFF, 16'h8000, 1'b0, 1'b1);
        chk("s_7fff_8000", 64'(dout_s), 64'hC000_8000);
        chk("s_7fff_8000_par", 64'(dpar_s), 64'h1);
        chk("u_7fff_8000", 64'(dout_u), 64'h3FFF_8000);
        idle(2, 1'b1);
        pair_to_head(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        chk("s_ffff_sq", 64'(dout_s), 64'h0000_0001);
        chk("u_ffff_sq", 64'(dout_u), 64'hFFFE_0001);
        chk("u_ffff_sq_par", 64'(dpar_u), 64'h0);
        idle(2, 1'b1);
        pair_to_head(16'h0000, 16'h1234, 1'b0, 1'b1);
        chk("u_zero", 64'(dout_u), 64'h0);
        chk("u_zero_valid", 64'(dval_u), 64'h1);

        // 4: bad parity on A, then a good pair
        idle(2, 1'b1);
        pair_to_head(16'h0003, 16'h0005, 1'b1, 1'b1);
        chk("perr_flag", 64'(derr_s), 64'h1);
        chk("perr_data", 64'(dout_s), 64'h0);
        idle(2, 1'b1);
        pair_to_head(16'h0003, 16'h0005, 1'b0, 1'b1);
        chk("good_after_err", 64'(dout_u), 64'h0000_000F);
        chk("good_after_err_flag", 64'(derr_u), 64'h0);

        // 5: backpressure fills the FIFO, a 5th A is dropped
        idle(3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 16'(i + 2), 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 16'(i + 10), 1'b0, 1'b0);
        end
        chk("bp_busy_after_4th_b", 64'(busy_s), 64'h1);
        cyc(1'b0, 1'b1, 16'h0077, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("bp_count_full", 64'(cnt_s), 64'h4);
        idle(6, 1'b1);
        chk("bp_busy_released", 64'(busy_u), 64'h0);
        chk("bp_drained", 64'(cnt_u), 64'h0);

        // 6: random corner operands with ready toggling every cycle
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b1, corner(), ($urandom_range(0, 9) == 0), 1'(i % 2));
        end
        idle(14, 1'b1);
        chk("rand_drained", 64'(cnt_s), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
